// File: rtl/lsu_bus_wb_gen_pkg.sv
// Shared widths and encodings for the LSU bus writeback path.
// Every file of the block takes its default sizes and the access-size encoding from here.
package lsu_bus_wb_gen_pkg;

    localparam int DEF_XLEN               = 64;
    localparam int DEF_ROB_INDEX_WIDTH    = 6;
    localparam int DEF_PHY_REG_ADDR_WIDTH = 6;
    localparam int DEF_BUS_OUTSTANDING    = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } size_e;

endpackage

// File: rtl/lsu_bus_ctx_fifo.sv
// In-order context FIFO for outstanding bus requests.
// A push and a pop may share a cycle at any occupancy, including full.
module lsu_bus_ctx_fifo
    import lsu_bus_wb_gen_pkg::*;
#(
    parameter int DEPTH = DEF_BUS_OUTSTANDING,
    parameter int W     = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         clear,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wrap_inc(wr_ptr);
            if (pop)  rd_ptr <= wrap_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/lsu_bus_wb_gen.sv
// Bus response writeback generator: pairs in-order bus responses with issued
// request contexts, formats load data and presents one completion at a time.
module lsu_bus_wb_gen
    import lsu_bus_wb_gen_pkg::*;
#(
    parameter int XLEN               = DEF_XLEN,
    parameter int ROB_INDEX_WIDTH    = DEF_ROB_INDEX_WIDTH,
    parameter int PHY_REG_ADDR_WIDTH = DEF_PHY_REG_ADDR_WIDTH,
    parameter int BUS_OUTSTANDING    = DEF_BUS_OUTSTANDING
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush,
    input  logic                          lsq_req_vld_i,
    output logic                          lsq_req_rdy_o,
    input  logic [ROB_INDEX_WIDTH-1:0]    lsq_req_rob_index_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] lsq_req_rd_addr_i,
    input  logic                          lsq_req_is_load_i,
    input  logic [1:0]                    lsq_req_size_i,
    input  logic                          lsq_req_sext_i,
    input  logic [2:0]                    lsq_req_offset_i,
    input  logic                          bus_resp_vld_i,
    output logic                          bus_resp_rdy_o,
    input  logic [XLEN-1:0]               bus_resp_data_i,
    output logic                          bus_wb_arb_wb_vld_o,
    output logic [ROB_INDEX_WIDTH-1:0]    bus_wb_arb_wb_rob_index_o,
    output logic                          bus_wb_arb_prf_wb_vld_o,
    output logic [PHY_REG_ADDR_WIDTH-1:0] bus_wb_arb_prf_wb_rd_addr_o,
    output logic [XLEN-1:0]               bus_wb_arb_prf_wb_data_o,
    input  logic                          wb_arb_bus_rdy_i
);
    localparam int CW = $clog2(BUS_OUTSTANDING + 1);

    typedef struct packed {
        logic [ROB_INDEX_WIDTH-1:0]    rob_index;
        logic [PHY_REG_ADDR_WIDTH-1:0] rd_addr;
        logic                          is_load;
        logic [1:0]                    size;
        logic                          sext;
        logic [2:0]                    offset;
    } ctx_t;

    localparam int CTX_W = $bits(ctx_t);

    ctx_t                          push_ctx;
    ctx_t                          head_ctx;
    logic [CW-1:0]                 ctx_count;
    logic [CW-1:0]                 discard_count;
    logic                          push;
    logic                          resp_hs;
    logic                          pop;
    logic                          drop;
    logic                          load_out;

    logic                          vld_p1;
    logic [ROB_INDEX_WIDTH-1:0]    rob_p1;
    logic [PHY_REG_ADDR_WIDTH-1:0] rd_p1;
    logic                          is_load_p1;
    logic [XLEN-1:0]               data_p1;

    function automatic logic [XLEN-1:0] format_load(input logic [XLEN-1:0] beat,
                                                    input logic [2:0]      offset,
                                                    input size_e           size,
                                                    input logic            sext);
        logic [XLEN-1:0] shifted;
        logic [XLEN-1:0] result;
        shifted = beat >> {offset, 3'b000};
        case (size)
            SIZE_BYTE: result = {{(XLEN-8){sext & shifted[7]}},   shifted[7:0]};
            SIZE_HALF: result = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
            SIZE_WORD: result = {{(XLEN-32){sext & shifted[31]}}, shifted[31:0]};
            default:   result = shifted;
        endcase
        return result;
    endfunction

    assign push_ctx = '{rob_index: lsq_req_rob_index_i,
                        rd_addr:   lsq_req_rd_addr_i,
                        is_load:   lsq_req_is_load_i,
                        size:      lsq_req_size_i,
                        sext:      lsq_req_sext_i,
                        offset:    lsq_req_offset_i};

    // Responses still owed to flushed requests occupy bus slots too.
    assign lsq_req_rdy_o  = ~flush & (({1'b0, ctx_count} + {1'b0, discard_count})
                                      < (CW+1)'(BUS_OUTSTANDING));
    assign bus_resp_rdy_o = (discard_count != '0)
                          | ((ctx_count != '0) & (~vld_p1 | wb_arb_bus_rdy_i));

    assign push     = lsq_req_vld_i & lsq_req_rdy_o;
    assign resp_hs  = bus_resp_vld_i & bus_resp_rdy_o;
    assign drop     = resp_hs & (discard_count != '0);
    assign pop      = resp_hs & (discard_count == '0);
    assign load_out = pop & ~flush;

    lsu_bus_ctx_fifo #(
        .DEPTH (BUS_OUTSTANDING),
        .W     (CTX_W)
    ) u_ctx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (flush),
        .push      (push),
        .push_data (push_ctx),
        .pop       (pop),
        .pop_data  (head_ctx),
        .count     (ctx_count)
    );

    // Any response accepted in the flush cycle is already paid for.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            discard_count <= '0;
        end else if (flush) begin
            discard_count <= discard_count + ctx_count - CW'(resp_hs);
        end else if (drop) begin
            discard_count <= discard_count - CW'(1);
        end
    end

    // ---- stage p1: completion register ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (load_out) begin
            vld_p1 <= 1'b1;
        end else if (wb_arb_bus_rdy_i) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load_out) begin
            rob_p1     <= head_ctx.rob_index;
            rd_p1      <= head_ctx.rd_addr;
            is_load_p1 <= head_ctx.is_load;
            data_p1    <= format_load(bus_resp_data_i, head_ctx.offset,
                                      size_e'(head_ctx.size), head_ctx.sext);
        end
    end

    assign bus_wb_arb_wb_vld_o         = vld_p1;
    assign bus_wb_arb_wb_rob_index_o   = vld_p1 ? rob_p1 : '0;
    assign bus_wb_arb_prf_wb_vld_o     = vld_p1 & is_load_p1 & (rd_p1 != '0);
    assign bus_wb_arb_prf_wb_rd_addr_o = (vld_p1 & is_load_p1) ? rd_p1 : '0;
    assign bus_wb_arb_prf_wb_data_o    = (vld_p1 & is_load_p1) ? data_p1 : '0;

endmodule

// File: tb/tb_lsu_bus_wb_gen.sv
// Bench for lsu_bus_wb_gen: directed vectors, corner sequences and a
// randomized run against a queue-based reference model.
module tb_lsu_bus_wb_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        lsq_req_vld_i;
    logic        lsq_req_rdy_o;
    logic [5:0]  lsq_req_rob_index_i;
    logic [5:0]  lsq_req_rd_addr_i;
    logic        lsq_req_is_load_i;
    logic [1:0]  lsq_req_size_i;
    logic        lsq_req_sext_i;
    logic [2:0]  lsq_req_offset_i;
    logic        bus_resp_vld_i;
    logic        bus_resp_rdy_o;
    logic [63:0] bus_resp_data_i;
    logic        bus_wb_arb_wb_vld_o;
    logic [5:0]  bus_wb_arb_wb_rob_index_o;
    logic        bus_wb_arb_prf_wb_vld_o;
    logic [5:0]  bus_wb_arb_prf_wb_rd_addr_o;
    logic [63:0] bus_wb_arb_prf_wb_data_o;
    logic        wb_arb_bus_rdy_i;

    lsu_bus_wb_gen dut (
        .clk                         (clk),
        .rstn                        (rstn),
        .flush                       (flush),
        .lsq_req_vld_i               (lsq_req_vld_i),
        .lsq_req_rdy_o               (lsq_req_rdy_o),
        .lsq_req_rob_index_i         (lsq_req_rob_index_i),
        .lsq_req_rd_addr_i           (lsq_req_rd_addr_i),
        .lsq_req_is_load_i           (lsq_req_is_load_i),
        .lsq_req_size_i              (lsq_req_size_i),
        .lsq_req_sext_i              (lsq_req_sext_i),
        .lsq_req_offset_i            (lsq_req_offset_i),
        .bus_resp_vld_i              (bus_resp_vld_i),
        .bus_resp_rdy_o              (bus_resp_rdy_o),
        .bus_resp_data_i             (bus_resp_data_i),
        .bus_wb_arb_wb_vld_o         (bus_wb_arb_wb_vld_o),
        .bus_wb_arb_wb_rob_index_o   (bus_wb_arb_wb_rob_index_o),
        .bus_wb_arb_prf_wb_vld_o     (bus_wb_arb_prf_wb_vld_o),
        .bus_wb_arb_prf_wb_rd_addr_o (bus_wb_arb_prf_wb_rd_addr_o),
        .bus_wb_arb_prf_wb_data_o    (bus_wb_arb_prf_wb_data_o),
        .wb_arb_bus_rdy_i            (wb_arb_bus_rdy_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [5:0]  rob;
        logic [5:0]  rd;
        logic        ld;
        logic [1:0]  sz;
        logic        sx;
        logic [2:0]  off;
        logic [63:0] data;
        logic        exp_prf;
        logic [63:0] exp_data;
    } vec_t;

    typedef struct {
        logic [5:0] rob;
        logic [5:0] rd;
        logic       ld;
        logic [1:0] sz;
        logic       sx;
        logic [2:0] off;
    } mctx_t;

    vec_t  vecs[8];
    mctx_t q[$];
    int    owed;
    logic  mo_vld;
    mctx_t mo;
    logic [63:0] mo_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] rob, input logic [5:0] rd, input logic ld,
                         input logic [1:0] sz, input logic sx, input logic [2:0] off);
        lsq_req_vld_i       = 1'b1;
        lsq_req_rob_index_i = rob;
        lsq_req_rd_addr_i   = rd;
        lsq_req_is_load_i   = ld;
        lsq_req_size_i      = sz;
        lsq_req_sext_i      = sx;
        lsq_req_offset_i    = off;
    endtask

    // Reference formatting from the size/offset/sign rules, using masks.
    function automatic logic [63:0] fmt(input logic [63:0] d, input int off, input int sz,
                                        input logic sx);
        logic [63:0] v;
        logic [63:0] mask;
        int nb;
        nb = 8 << sz;
        v  = d >> (8 * off);
        if (nb < 64) begin
            mask = (64'd1 << nb) - 64'd1;
            v    = v & mask;
            if (sx && v[nb-1]) v = v | ~mask;
        end
        return v;
    endfunction

    initial begin
        rstn = 1'b0; flush = 1'b0; lsq_req_vld_i = 1'b0;
        lsq_req_rob_index_i = '0; lsq_req_rd_addr_i = '0; lsq_req_is_load_i = 1'b0;
        lsq_req_size_i = '0; lsq_req_sext_i = 1'b0; lsq_req_offset_i = '0;
        bus_resp_vld_i = 1'b0; bus_resp_data_i = '0; wb_arb_bus_rdy_i = 1'b0;

        vecs[0] = '{6'd3,  6'd7,  1'b1, 2'd0, 1'b1, 3'd5, 64'h0000_8000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[1] = '{6'd9,  6'd5,  1'b0, 2'd3, 1'b0, 3'd0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h0};
        vecs[2] = '{6'd12, 6'd0,  1'b1, 2'd1, 1'b0, 3'd6, 64'hABCD_0000_0000_0000, 1'b0, 64'h0};
        vecs[3] = '{6'd20, 6'd31, 1'b1, 2'd1, 1'b1, 3'd2, 64'h0000_0000_8765_0000, 1'b1, 64'hFFFF_FFFF_FFFF_8765};
        vecs[4] = '{6'd33, 6'd12, 1'b1, 2'd2, 1'b1, 3'd4, 64'h7FFF_FFFF_0000_0000, 1'b1, 64'h0000_0000_7FFF_FFFF};
        vecs[5] = '{6'd63, 6'd63, 1'b1, 2'd2, 1'b0, 3'd0, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 64'h0000_0000_CAFE_F00D};
        vecs[6] = '{6'd1,  6'd1,  1'b1, 2'd3, 1'b1, 3'd0, 64'h8000_0000_0000_0001, 1'b1, 64'h8000_0000_0000_0001};
        vecs[7] = '{6'd40, 6'd2,  1'b1, 2'd0, 1'b0, 3'd7, 64'hFE00_0000_0000_0000, 1'b1, 64'h0000_0000_0000_00FE};

        // Reset state
        #2;
        check("rst_wb_vld",    bus_wb_arb_wb_vld_o, 1'b0);
        check("rst_rob",       bus_wb_arb_wb_rob_index_o, 6'd0);
        check("rst_prf_vld",   bus_wb_arb_prf_wb_vld_o, 1'b0);
        check("rst_prf_rd",    bus_wb_arb_prf_wb_rd_addr_o, 6'd0);
        check("rst_prf_data",  bus_wb_arb_prf_wb_data_o, 64'd0);
        check("rst_resp_rdy",  bus_resp_rdy_o, 1'b0);
        check("rst_req_rdy",   lsq_req_rdy_o, 1'b1);
        @(posedge clk); #1;
        rstn = 1'b1;
        wb_arb_bus_rdy_i = 1'b1;
        step();

        // Single-transaction vectors
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].rob, vecs[i].rd, vecs[i].ld, vecs[i].sz, vecs[i].sx, vecs[i].off);
            #1 check("vec_req_rdy", lsq_req_rdy_o, 1'b1);
            step();
            lsq_req_vld_i   = 1'b0;
            bus_resp_vld_i  = 1'b1;
            bus_resp_data_i = vecs[i].data;
            #1;
            check("vec_resp_rdy", bus_resp_rdy_o, 1'b1);
            check("vec_not_early", bus_wb_arb_wb_vld_o, 1'b0);
            step();
            bus_resp_vld_i = 1'b0;
            check("vec_wb_vld",  bus_wb_arb_wb_vld_o, 1'b1);
            check("vec_rob",     bus_wb_arb_wb_rob_index_o, vecs[i].rob);
            check("vec_prf_vld", bus_wb_arb_prf_wb_vld_o, vecs[i].exp_prf);
            if (vecs[i].exp_prf || !vecs[i].ld)
                check("vec_prf_data", bus_wb_arb_prf_wb_data_o, vecs[i].exp_data);
            if (vecs[i].exp_prf)
                check("vec_prf_rd", bus_wb_arb_prf_wb_rd_addr_o, vecs[i].rd);
            step();
            check("vec_cleared", bus_wb_arb_wb_vld_o, 1'b0);
        end

        // Fill to capacity with the output held by the arbiter
        wb_arb_bus_rdy_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            issue(6'(k), 6'(k + 1), 1'b1, 2'd3, 1'b0, 3'd0);
            step();
        end
        lsq_req_vld_i = 1'b0;
        #1;
        check("full_req_rdy",  lsq_req_rdy_o, 1'b0);
        check("full_resp_rdy", bus_resp_rdy_o, 1'b1);
        bus_resp_vld_i  = 1'b1;
        bus_resp_data_i = 64'h100;
        step();
        bus_resp_vld_i = 1'b0;
        for (int h = 0; h < 3; h++) begin
            check("hold_wb_vld",    bus_wb_arb_wb_vld_o, 1'b1);
            check("hold_rob",       bus_wb_arb_wb_rob_index_o, 6'd0);
            check("hold_prf_data",  bus_wb_arb_prf_wb_data_o, 64'h100);
            check("hold_resp_rdy",  bus_resp_rdy_o, 1'b0);
            step();
        end
        wb_arb_bus_rdy_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("order_wb_vld",   bus_wb_arb_wb_vld_o, 1'b1);
            check("order_rob",      bus_wb_arb_wb_rob_index_o, 6'(k));
            check("order_prf_data", bus_wb_arb_prf_wb_data_o, 64'h100 + 64'(k));
            bus_resp_vld_i  = (k < 3);
            bus_resp_data_i = 64'h100 + 64'(k + 1);
            step();
        end
        bus_resp_vld_i = 1'b0;
        #1;
        check("drain_wb_vld",   bus_wb_arb_wb_vld_o, 1'b0);
        check("drain_resp_rdy", bus_resp_rdy_o, 1'b0);
        check("drain_req_rdy",  lsq_req_rdy_o, 1'b1);
        step();

        // Flush with two requests in flight
        issue(6'd10, 6'd3, 1'b1, 2'd3, 1'b0, 3'd0);
        step();
        issue(6'd11, 6'd4, 1'b1, 2'd3, 1'b0, 3'd0);
        step();
        lsq_req_vld_i = 1'b0;
        flush = 1'b1;
        #1 check("flush_req_rdy", lsq_req_rdy_o, 1'b0);
        step();
        flush = 1'b0;
        #1;
        check("owed_req_rdy",  lsq_req_rdy_o, 1'b1);
        check("owed_resp_rdy", bus_resp_rdy_o, 1'b1);
        bus_resp_vld_i  = 1'b1;
        bus_resp_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        check("drop1_wb_vld", bus_wb_arb_wb_vld_o, 1'b0);
        step();
        check("drop2_wb_vld",   bus_wb_arb_wb_vld_o, 1'b0);
        check("stray_resp_rdy", bus_resp_rdy_o, 1'b0);
        step();
        check("stray_wb_vld", bus_wb_arb_wb_vld_o, 1'b0);
        bus_resp_vld_i = 1'b0;
        issue(6'd12, 6'd9, 1'b1, 2'd2, 1'b0, 3'd0);
        step();
        lsq_req_vld_i   = 1'b0;
        bus_resp_vld_i  = 1'b1;
        bus_resp_data_i = 64'h1111_2222_3333_4444;
        step();
        bus_resp_vld_i = 1'b0;
        check("post_flush_wb_vld", bus_wb_arb_wb_vld_o, 1'b1);
        check("post_flush_rob",    bus_wb_arb_wb_rob_index_o, 6'd12);
        check("post_flush_data",   bus_wb_arb_prf_wb_data_o, 64'h3333_4444);
        step();

        // Reset while a completion is held
        wb_arb_bus_rdy_i = 1'b0;
        issue(6'd5, 6'd4, 1'b1, 2'd3, 1'b0, 3'd0);
        step();
        lsq_req_vld_i   = 1'b0;
        bus_resp_vld_i  = 1'b1;
        bus_resp_data_i = 64'hAA;
        step();
        bus_resp_vld_i = 1'b0;
        check("pre_rst_wb_vld", bus_wb_arb_wb_vld_o, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("async_wb_vld",   bus_wb_arb_wb_vld_o, 1'b0);
        check("async_rob",      bus_wb_arb_wb_rob_index_o, 6'd0);
        check("async_prf_vld",  bus_wb_arb_prf_wb_vld_o, 1'b0);
        check("async_prf_data", bus_wb_arb_prf_wb_data_o, 64'd0);
        check("async_req_rdy",  lsq_req_rdy_o, 1'b1);
        step();
        rstn = 1'b1;
        wb_arb_bus_rdy_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("after_rst_wb_vld",   bus_wb_arb_wb_vld_o, 1'b0);
            check("after_rst_resp_rdy", bus_resp_rdy_o, 1'b0);
        end

        // Randomized traffic against the queue model
        q.delete();
        owed   = 0;
        mo_vld = 1'b0;
        mo     = '{default: '0};
        mo_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic  exp_req_rdy;
            logic  exp_resp_rdy;
            logic  new_v;
            mctx_t c;
            logic [63:0] nd;
            check("rnd_wb_vld", bus_wb_arb_wb_vld_o, mo_vld);
            if (mo_vld) begin
                check("rnd_rob",     bus_wb_arb_wb_rob_index_o, mo.rob);
                check("rnd_prf_vld", bus_wb_arb_prf_wb_vld_o, mo.ld && (mo.rd != 0));
                if (!mo.ld) check("rnd_store_data", bus_wb_arb_prf_wb_data_o, 64'd0);
                if (mo.ld && mo.rd != 0) begin
                    check("rnd_prf_rd",   bus_wb_arb_prf_wb_rd_addr_o, mo.rd);
                    check("rnd_prf_data", bus_wb_arb_prf_wb_data_o, mo_data);
                end
            end
            flush            = ($urandom_range(0, 39) == 0);
            wb_arb_bus_rdy_i = ($urandom_range(0, 3) != 0);
            bus_resp_vld_i   = ($urandom_range(0, 3) != 0);
            bus_resp_data_i  = {$urandom, $urandom};
            issue(6'($urandom_range(0, 63)),
                  ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
                  1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            lsq_req_vld_i = 1'($urandom_range(0, 1));
            #1;
            exp_req_rdy  = !flush && (q.size() + owed < 4);
            exp_resp_rdy = (owed != 0) || (q.size() != 0 && (!mo_vld || wb_arb_bus_rdy_i));
            check("rnd_req_rdy",  lsq_req_rdy_o, exp_req_rdy);
            check("rnd_resp_rdy", bus_resp_rdy_o, exp_resp_rdy);

            new_v = 1'b0;
            c     = '{default: '0};
            nd    = '0;
            if (bus_resp_vld_i && exp_resp_rdy) begin
                if (owed > 0) owed--;
                else begin
                    c     = q.pop_front();
                    new_v = 1'b1;
                    nd    = fmt(bus_resp_data_i, int'(c.off), int'(c.sz), c.sx);
                end
            end
            if (flush) begin
                owed += q.size();
                q.delete();
                mo_vld = 1'b0;
            end else if (new_v) begin
                mo_vld  = 1'b1;
                mo      = c;
                mo_data = nd;
            end else if (wb_arb_bus_rdy_i) begin
                mo_vld = 1'b0;
            end
            if (lsq_req_vld_i && exp_req_rdy)
                q.push_back('{lsq_req_rob_index_i, lsq_req_rd_addr_i, lsq_req_is_load_i,
                              lsq_req_size_i, lsq_req_sext_i, lsq_req_offset_i});
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
